// File: rtl/read_queue_scheduler_pkg.sv
// Shared scheduler definitions for the read and write queue arbiters:
// FSM state encoding, queue-index type and default sizing constants.
package read_queue_scheduler_pkg;

  localparam int DEF_NUM_QUEUES   = 8;
  localparam int DEF_QID_WIDTH    = 3;
  localparam int DEF_WEIGHT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } sched_state_t;

  typedef logic [DEF_QID_WIDTH-1:0] qid_t;

endpackage

// File: rtl/read_queue_scheduler_selector.sv
// read_queue_selector: combinational queue pick (strict priority, or
// weighted round robin when READ_WRR_EN is defined) plus the WRR credit
// registers. Credits only move on a grant taken while in WRR mode.
module read_queue_selector
  import read_queue_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES   = DEF_NUM_QUEUES,
  parameter int QID_WIDTH    = DEF_QID_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wrr_mode,
  input  logic [NUM_QUEUES-1:0]              q_nonempty,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  input  logic                               take,
  output logic [QID_WIDTH-1:0]               sel_qid,
  output logic                               sel_valid
);

  logic [QID_WIDTH-1:0] sp_qid;

  assign sel_valid = |q_nonempty;

  // Strict priority: highest nonempty index wins (later iterations override).
  always_comb begin
    sp_qid = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      if (q_nonempty[i]) sp_qid = QID_WIDTH'(i);
  end

`ifdef READ_WRR_EN
  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] credit;
  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] reload_val;
  logic [NUM_QUEUES-1:0]                   eligible;
  logic [QID_WIDTH-1:0]                    wrr_qid;
  logic                                    reload;

  // Reload values (zero weight treated as one) and credit eligibility.
  always_comb begin
    reload_val = '0;
    eligible   = '0;
    wrr_qid    = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      reload_val[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (reload_val[i] == '0) reload_val[i] = WEIGHT_WIDTH'(1);
      eligible[i] = q_nonempty[i] && (credit[i] != '0);
      if (eligible[i]) wrr_qid = QID_WIDTH'(i);
    end
  end

  // After a reload every credit is nonzero, so the WRR pick equals the SP pick.
  assign reload  = !(|eligible) && (|q_nonempty);
  assign sel_qid = (wrr_mode && !reload) ? wrr_qid : sp_qid;

  // Credit update on a WRR grant: reload-and-spend, or spend one credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
    end else if (take && wrr_mode) begin
      if (reload) begin
        credit         <= reload_val;
        credit[sp_qid] <= reload_val[sp_qid] - WEIGHT_WIDTH'(1);
      end else begin
        credit[wrr_qid] <= credit[wrr_qid] - WEIGHT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, wrr_mode, weights, take};
  assign sel_qid       = sp_qid;
`endif

endmodule

// File: rtl/read_queue_scheduler.sv
// read_queue_scheduler: picks a packet queue, issues a one-cycle dequeue
// request to the SRAM read controller, and streams the packet through a
// one-entry output register with valid/ready handshaking.
// Optional WRR selection is enabled with the READ_WRR_EN macro.
module read_queue_scheduler
  import read_queue_scheduler_pkg::*;
#(
  parameter int NUM_QUEUES   = DEF_NUM_QUEUES,
  parameter int QID_WIDTH    = DEF_QID_WIDTH,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sp0_wrr1,
  input  logic [NUM_QUEUES-1:0]              q_nonempty,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  output logic                               rd_req,
  output logic [QID_WIDTH-1:0]               rd_qid,
  input  logic                               rd_valid,
  input  logic [DATA_WIDTH-1:0]              rd_data,
  input  logic                               rd_eop,
  output logic                               rd_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_sop,
  output logic                               out_eop,
  input  logic                               out_ready,
  output logic                               busy
);

  sched_state_t         state, state_next;
  logic [QID_WIDTH-1:0] sel_qid;
  logic                 sel_valid;
  logic                 take;
  logic                 accept;
  logic                 out_fire;
  logic                 eop_taken;
  logic                 sop_pending;

  read_queue_selector #(
    .NUM_QUEUES  (NUM_QUEUES),
    .QID_WIDTH   (QID_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_sel (
    .clk       (clk),
    .rst       (rst),
    .wrr_mode  (sp0_wrr1),
    .q_nonempty(q_nonempty),
    .weights   (weights),
    .take      (take),
    .sel_qid   (sel_qid),
    .sel_valid (sel_valid)
  );

  assign accept   = rd_valid && rd_ready;
  assign out_fire = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    rd_ready   = 1'b0;
    busy       = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          take       = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        rd_req     = 1'b1;
        busy       = 1'b1;
        state_next = XFER;
      end
      XFER: begin
        busy     = 1'b1;
        rd_ready = (!out_valid || out_ready) && !eop_taken;
        if (out_fire && out_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Granted queue id, packet framing flags and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_qid      <= '0;
      eop_taken   <= 1'b0;
      sop_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
    end else begin
      if (take) rd_qid <= sel_qid;
      if (state == GRANT) begin
        sop_pending <= 1'b1;
        eop_taken   <= 1'b0;
      end
      if (accept) begin
        out_valid   <= 1'b1;
        out_data    <= rd_data;
        out_sop     <= sop_pending;
        out_eop     <= rd_eop;
        sop_pending <= 1'b0;
        if (rd_eop) eop_taken <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_read_queue_scheduler.sv
// Self-checking bench for read_queue_scheduler: grant and beat scoreboards,
// strict priority, WRR ordering (SP when READ_WRR_EN is undefined),
// backpressure, single-word packets and mid-packet reset.
module tb_read_queue_scheduler;

  logic        clk;
  logic        rst;
  logic        sp0_wrr1;
  logic [7:0]  q_nonempty;
  logic [31:0] weights;
  logic        rd_req;
  logic [2:0]  rd_qid;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_eop;
  logic        rd_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t      exp_q[$];
  logic [2:0] grant_q[$];
  int         total;
  int         passed;

  read_queue_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .sp0_wrr1  (sp0_wrr1),
    .q_nonempty(q_nonempty),
    .weights   (weights),
    .rd_req    (rd_req),
    .rd_qid    (rd_qid),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_eop    (rd_eop),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Waits for a grant, checks it against the grant scoreboard, then acts as
  // the SRAM read side for an n-word packet, checking each output beat.
  // Output backpressure is applied for bp_len cycles starting at bp_start.
  task automatic run_pkt(input int n, input logic [15:0] base, input logic clr,
                         input int bp_start, input int bp_len, output int wait_cyc);
    beat_t       e;
    logic [2:0]  g;
    logic [15:0] held;
    int          w, pushed, cyc;
    bit          done;
    wait_cyc = 0;
    while (wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
      if (rd_req) break;
    end
    total++;
    if (!rd_req) begin
      $display("FAIL grant_timeout: rd_req=%0b after %0d cycles, required 1", rd_req, wait_cyc);
      return;
    end
    if (grant_q.size() == 0) begin
      $display("FAIL grant_unexpected: rd_qid=%0d, no grant expected", rd_qid);
    end else begin
      g = grant_q.pop_front();
      if (rd_qid !== g) $display("FAIL grant_qid: rd_qid=%0d required %0d", rd_qid, g);
      else passed++;
    end
    if (clr) q_nonempty = '0;
    w = 0; pushed = 0; cyc = 0; done = 0; held = '0;
    while (!done && cyc < 100) begin
      @(posedge clk); #2;
      if (w < n) begin
        rd_valid = 1'b1;
        rd_data  = base + 16'(w);
        rd_eop   = (w == n - 1);
        if (pushed == w) begin
          exp_q.push_back('{rd_data, (w == 0), (w == n - 1)});
          pushed++;
        end
      end else begin
        rd_valid = 1'b0;
        rd_eop   = 1'b0;
      end
      out_ready = !(cyc >= bp_start && cyc < bp_start + bp_len);
      @(negedge clk);
      if (!out_ready) begin
        total++;
        if (rd_ready !== 1'b0) $display("FAIL bp_rd_ready: rd_ready=%0b required 0", rd_ready);
        else passed++;
        if (cyc == bp_start) held = out_data;
        else begin
          total++;
          if (out_valid !== 1'b1 || out_data !== held)
            $display("FAIL bp_hold: out_valid=%0b out_data=%h required 1/%h", out_valid, out_data, held);
          else passed++;
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: out_data=%h sop=%0b eop=%0b", out_data, out_sop, out_eop);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_sop, out_eop} !== e)
            $display("FAIL beat: data=%h sop=%0b eop=%0b required data=%h sop=%0b eop=%0b",
                     out_data, out_sop, out_eop, e.data, e.sop, e.eop);
          else passed++;
          if (e.eop) done = 1;
        end
      end
      if (rd_valid && rd_ready) w++;
      cyc++;
    end
    total++;
    if (!done) $display("FAIL pkt_timeout: eop beat not seen after %0d cycles", cyc);
    else passed++;
    @(posedge clk); #2;
    rd_valid  = 1'b0;
    rd_eop    = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sp0_wrr1 = 1'b0; q_nonempty = '0; weights = '0;
    rd_valid = 1'b1; rd_data = 16'hBEEF; rd_eop = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req: %0b required 0", rd_req); else passed++;
    total++; if (rd_qid !== 3'd0) $display("FAIL reset_rd_qid: %0d required 0", rd_qid); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: %0b required 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL reset_out_data: %h required 0", out_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: %0b required 0", busy); else passed++;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b0) $display("FAIL idle_rd_ready: %0b required 0 with rd_valid in IDLE", rd_ready);
    else passed++;
    @(posedge clk); #2;
    rd_valid = 1'b0;
  endtask

  task automatic test_sp();
    int wc;
    @(posedge clk); #2;
    sp0_wrr1   = 1'b0;
    q_nonempty = 8'b0010_0110;
    grant_q.push_back(3'd5);
    run_pkt(3, 16'h0100, 1'b0, 0, 0, wc);
    q_nonempty = 8'b0000_0110;
    grant_q.push_back(3'd2);
    run_pkt(2, 16'h0110, 1'b1, 0, 0, wc);
  endtask

  task automatic test_wrr();
    int         wc;
    logic [2:0] order [8];
`ifdef READ_WRR_EN
    order = '{3'd7, 3'd7, 3'd3, 3'd0, 3'd7, 3'd7, 3'd3, 3'd0};
`else
    order = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    @(posedge clk); #2;
    sp0_wrr1   = 1'b1;
    weights    = 32'h2000_1000;
    q_nonempty = 8'b1000_1001;
    for (int k = 0; k < 8; k++) begin
      grant_q.push_back(order[k]);
      run_pkt(1, 16'h0200 + 16'(k), (k == 7), 0, 0, wc);
    end
    sp0_wrr1 = 1'b0;
  endtask

  task automatic test_backpressure();
    int wc;
    @(posedge clk); #2;
    q_nonempty = 8'b0000_0100;
    grant_q.push_back(3'd2);
    run_pkt(5, 16'h0300, 1'b1, 2, 4, wc);
    total++;
    if (exp_q.size() != 0) $display("FAIL bp_leftover: %0d beats undelivered, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_single();
    int wc;
    @(posedge clk); #2;
    q_nonempty = 8'b0001_0000;
    grant_q.push_back(3'd4);
    grant_q.push_back(3'd4);
    run_pkt(1, 16'h0400, 1'b0, 0, 0, wc);
    total++;
    if (wc != 2) $display("FAIL req_latency: rd_req at sample %0d required 2", wc);
    else passed++;
    run_pkt(1, 16'h0401, 1'b1, 0, 0, wc);
    total++;
    if (wc != 2) $display("FAIL idle_gap: rd_req at sample %0d after eop required 2", wc);
    else passed++;
  endtask

  task automatic test_reset_mid_xfer();
    int wc;
    @(posedge clk); #2;
    q_nonempty = 8'b0000_0010;
    wc = 0;
    while (wc < 20) begin
      @(negedge clk);
      wc++;
      if (rd_req) break;
    end
    total++;
    if (rd_req !== 1'b1 || rd_qid !== 3'd1)
      $display("FAIL rmx_grant: rd_req=%0b rd_qid=%0d required 1/1", rd_req, rd_qid);
    else passed++;
    q_nonempty = '0;
    @(posedge clk); #2;
    out_ready = 1'b0; rd_valid = 1'b1; rd_data = 16'hDEAD; rd_eop = 1'b0;
    @(posedge clk); #2;
    rd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hDEAD)
      $display("FAIL rmx_loaded: out_valid=%0b out_data=%h required 1/dead", out_valid, out_data);
    else passed++;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (rd_req !== 1'b0) $display("FAIL rmx_rd_req: %0b required 0", rd_req); else passed++;
    total++; if (rd_qid !== 3'd0) $display("FAIL rmx_rd_qid: %0d required 0", rd_qid); else passed++;
    total++; if (rd_ready !== 1'b0) $display("FAIL rmx_rd_ready: %0b required 0", rd_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rmx_out_valid: %0b required 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL rmx_out_data: %h required 0", out_data); else passed++;
    total++; if (out_sop !== 1'b0 || out_eop !== 1'b0)
      $display("FAIL rmx_sop_eop: %0b/%0b required 0/0", out_sop, out_eop); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmx_busy: %0b required 0", busy); else passed++;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    q_nonempty = 8'b0001_0000;
    grant_q.push_back(3'd4);
    run_pkt(2, 16'h0500, 1'b1, 0, 0, wc);
  endtask

  task automatic test_quiet();
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL quiet: busy=%0b out_valid=%0b required 0/0", busy, out_valid);
    else passed++;
    total++;
    if (grant_q.size() != 0) $display("FAIL grants_left: %0d required 0", grant_q.size());
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_sp();
    test_wrr();
    test_backpressure();
    test_single();
    test_reset_mid_xfer();
    test_quiet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/read_queue_scheduler.md
# read_queue_scheduler

Output-side scheduler of the SRAM controller: for one output port it picks one of the per-priority packet queues, requests that queue's head packet from the SRAM read controller, and streams the words to the port with valid/ready handshaking. It mirrors the input-side write arbitration. Strict-priority (SP) and weighted-round-robin (WRR) selection are supported, with one packet in flight at a time.

## Interface
- NUM_QUEUES, 8, number of priority queues; a higher index means higher priority.
- QID_WIDTH, 3, width of the queue index; must equal clog2(NUM_QUEUES).
- DATA_WIDTH, 16, width of a packet word.
- WEIGHT_WIDTH, 4, width of one WRR weight.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sp0_wrr1  in  1  selection mode: 0 = SP, 1 = WRR. Sampled only in IDLE.
- q_nonempty  in  NUM_QUEUES  queue i holds at least one complete packet.
- weights  in  NUM_QUEUES*WEIGHT_WIDTH  packed WRR weights; queue i uses bits [(i+1)*WEIGHT_WIDTH-1 : i*WEIGHT_WIDTH].
- rd_req  out  1  one-cycle dequeue request to the SRAM read controller.
- rd_qid  out  QID_WIDTH  queue being dequeued; valid while rd_req is high and held through XFER.
- rd_valid  in  1  rd_data is valid.
- rd_data  in  DATA_WIDTH  packet word from SRAM.
- rd_eop  in  1  last word of the packet, qualified by rd_valid.
- rd_ready  out  1  scheduler accepts rd_data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  DATA_WIDTH  packet word to the port.
- out_sop  out  1  first word of the packet.
- out_eop  out  1  last word of the packet.
- out_ready  in  1  port accepts the word.
- busy  out  1  high in GRANT and XFER.

## Operation
State machine:
- IDLE → GRANT when the selected queue is valid (at least one q_nonempty bit set). The selection is made combinationally in IDLE and registered into rd_qid on that transition.
- GRANT: rd_req = 1 for exactly one cycle, then → XFER.
- XFER: words move from rd_data into a one-entry output register.
  - rd_ready = (state == XFER) && (!out_valid || out_ready) && !eop_taken.
  - eop_taken is set when the rd_eop word is accepted.
  - → IDLE when the output register holding the eop word is accepted by the port (out_valid && out_ready && out_eop).

SP selection:
- Pick the highest index i with q_nonempty[i] set.

WRR selection:
- Each queue has a credit counter, WEIGHT_WIDTH bits wide.
- Eligible queues are those that are nonempty and have credit > 0. Pick the highest eligible index and decrement its credit on the IDLE → GRANT transition.
- If no queue is eligible but some queue is nonempty, reload all credits from weights (a weight of 0 loads as 1), then select with the reloaded values in the same cycle.

Other rules:
- out_sop is set on the first word accepted after GRANT and cleared on every following word.
- A change of sp0_wrr1 or of weights during GRANT/XFER has no effect until the next IDLE.
- Credits persist across mode switches.
- A word with rd_valid high outside XFER is ignored (rd_ready = 0).

## Timing
- Reset values: state IDLE, rd_req 0, rd_qid 0, rd_ready 0, out_valid 0, out_data 0, out_sop 0, out_eop 0, busy 0, all credits 0.
- Reset mid-packet drops the in-flight word and returns to IDLE next cycle. No partial eop is generated.
- Latency from q_nonempty rising (while in IDLE) to rd_req: 1 cycle.
- rd_data to out_data: 1 cycle (registered).
- With no backpressure, the output sustains 1 word per cycle.
- After the eop word is accepted there is at least 1 idle cycle (IDLE) before the next rd_req.
- A single-word packet (rd_eop on the first word) gives one output beat with both out_sop and out_eop set.
- If out_ready is held at 0, out_valid and out_data stay stable and rd_ready = 0.

## Configuration
- READ_WRR_EN defined: WRR logic, credit counters and the weights port are active.
- READ_WRR_EN undefined: sp0_wrr1 and weights are ignored and selection is always SP. The credit logic is not synthesized; the ports stay present.

## Structure
- Shared package: state encoding (IDLE, GRANT, XFER), a QID_WIDTH-bit queue-index type, and the default NUM_QUEUES / WEIGHT_WIDTH constants. Both write-side and read-side blocks use this package.
- One sub-module, read_queue_selector: combinational SP/WRR pick plus the credit registers and reload. It outputs sel_qid and sel_valid.

## Test plan
- SP, q_nonempty = 8'b0010_0110, 3-word packet, out_ready = 1 → rd_qid = 5; out_sop on word 0, out_eop on word 2; next grant rd_qid = 2.
- WRR, weights q7 = 2, q3 = 1, others 0, q7/q3/q0 always nonempty, 1-word packets → grant order 7,7,3,0,7,7,3,0.
- Backpressure: out_ready = 0 for 4 cycles mid-packet → out_data held stable, rd_ready = 0, no word lost or duplicated.
- Single-word packet, rd_eop on the first word → one beat with out_sop = out_eop = 1, then IDLE, then the next rd_req 1 cycle later.
- rst asserted during XFER → all outputs at reset values next cycle; after reset, q_nonempty[4] alone → rd_qid = 4.
- READ_WRR_EN undefined, sp0_wrr1 = 1, q_nonempty = 8'b1000_0001 → always rd_qid = 7 (SP).
